// File: rtl/branch_pc_unit.sv
// branch_pc_unit: owns the 16-bit PC and resolves branch-if-greater requests.
// A branch is accepted in RUN, resolved one edge later in RESOLVE, and a taken
// branch holds fetch off through a FLUSH window of FLUSH_CYCLES cycles.
module branch_pc_unit #(
  parameter logic [15:0] RESET_PC     = 16'h0000,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        stall,
  input  logic        br_valid,
  input  logic [15:0] br_target,
  input  logic        gt_flag,
  input  logic [15:0] gt_mask,
  output logic        br_ready,
  output logic [15:0] pc,
  output logic        pc_valid,
  output logic        taken,
  output logic        flush,
  output logic        flag_err,
  output logic [7:0]  taken_count
);

  typedef enum logic [1:0] {RUN, RESOLVE, FLUSH} state_e;

  // Counter reload leaves FLUSH on the edge where it reaches zero, giving
  // exactly FLUSH_CYCLES cycles of flush.
  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] tgt_q, tgt_d;
  logic        flag_q, flag_d;
  logic [15:0] mask_q, mask_d;
  logic        taken_q, taken_d;
  logic        err_q, err_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  tcnt_q, tcnt_d;
  logic        mismatch;

  assign br_ready    = (state_q == RUN) && !stall;
  assign pc          = pc_q;
  assign pc_valid    = (state_q == RUN);
  assign flush       = (state_q == FLUSH);
  assign taken       = taken_q;
  assign flag_err    = err_q;
  assign taken_count = tcnt_q;
  assign mismatch    = (mask_q != {16{flag_q}});

  // Next-state and datapath decisions for the three-state branch pipeline.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    tgt_d   = tgt_q;
    flag_d  = flag_q;
    mask_d  = mask_q;
    taken_d = 1'b0;
    err_d   = err_q;
    cnt_d   = cnt_q;
    tcnt_d  = tcnt_q;
    case (state_q)
      RUN: begin
        if (br_valid && br_ready) begin
          // Branch wins over a simultaneous en; operands are captured only here.
          tgt_d   = br_target;
          flag_d  = gt_flag;
          mask_d  = gt_mask;
          state_d = RESOLVE;
        end else if (!stall && en) begin
          pc_d = pc_q + 16'd1;
        end
      end
      RESOLVE: begin
        if (mismatch) err_d = 1'b1;
        if (flag_q && !mismatch) begin
          pc_d    = tgt_q;
          taken_d = 1'b1;
          if (tcnt_q != 8'hFF) tcnt_d = tcnt_q + 8'd1;
          cnt_d   = FLUSH_LOAD;
          state_d = FLUSH;
        end else begin
          pc_d    = pc_q + 16'd1;
          state_d = RUN;
        end
      end
      FLUSH: begin
        if (cnt_q == 4'd0) state_d = RUN;
        else               cnt_d   = cnt_q - 4'd1;
      end
      default: state_d = RUN;
    endcase
  end

  // State registers; asynchronous reset discards any in-flight branch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      tgt_q   <= 16'h0000;
      flag_q  <= 1'b0;
      mask_q  <= 16'h0000;
      taken_q <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= 4'd0;
      tcnt_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      tgt_q   <= tgt_d;
      flag_q  <= flag_d;
      mask_q  <= mask_d;
      taken_q <= taken_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      tcnt_q  <= tcnt_d;
    end
  end

endmodule

// File: tb/tb_branch_pc_unit.sv
// Directed bench for branch_pc_unit with hand-computed expectations.
module tb_branch_pc_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en, stall, br_valid, gt_flag;
  logic [15:0] br_target, gt_mask;
  logic        br_ready, pc_valid, taken, flush, flag_err;
  logic [15:0] pc;
  logic [7:0]  taken_count;

  int checks = 0;
  int errors = 0;

  branch_pc_unit #(.RESET_PC(16'h0000), .FLUSH_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .stall(stall),
    .br_valid(br_valid), .br_target(br_target), .gt_flag(gt_flag),
    .gt_mask(gt_mask), .br_ready(br_ready), .pc(pc), .pc_valid(pc_valid),
    .taken(taken), .flush(flush), .flag_err(flag_err),
    .taken_count(taken_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a branch, let it be accepted, then withdraw the request.
  task automatic accept(input logic [15:0] tgt, input logic f, input logic [15:0] m);
    br_valid = 1'b1; br_target = tgt; gt_flag = f; gt_mask = m;
    step();
    br_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; stall = 1'b0; br_valid = 1'b0;
    br_target = 16'h0; gt_flag = 1'b0; gt_mask = 16'h0;
    #12;
    chk("rst_pc", pc, 16'h0000);
    chk("rst_pc_valid", 16'(pc_valid), 16'h1);
    chk("rst_taken", 16'(taken), 16'h0);
    chk("rst_flush", 16'(flush), 16'h0);
    chk("rst_flag_err", 16'(flag_err), 16'h0);
    chk("rst_taken_count", 16'(taken_count), 16'h0);
    chk("rst_br_ready", 16'(br_ready), 16'h1);
    rst_n = 1'b1;
    step();

    // Sequential fetch
    en = 1'b1;
    step(); chk("inc1", pc, 16'h0001);
    step(); chk("inc2", pc, 16'h0002);
    step(); chk("inc3", pc, 16'h0003);
    chk("inc_pc_valid", 16'(pc_valid), 16'h1);
    chk("inc_flush", 16'(flush), 16'h0);
    en = 1'b0;

    // Taken branch to FFFE, then wrap through FFFF -> 0000
    accept(16'hFFFE, 1'b1, 16'hFFFF);
    chk("t0_resolve_ready", 16'(br_ready), 16'h0);
    step(); chk("t0_pc", pc, 16'hFFFE);
    step();
    step(); chk("t0_back_run", 16'(pc_valid), 16'h1);
    en = 1'b1;
    step(); chk("wrap_ffff", pc, 16'hFFFF);
    step(); chk("wrap_0000", pc, 16'h0000);
    en = 1'b0;

    // Taken branch to 0x0040 with full timing checks
    accept(16'h0040, 1'b1, 16'hFFFF);
    br_target = 16'h1234; // must be ignored after acceptance
    chk("t1_ready_c1", 16'(br_ready), 16'h0);
    chk("t1_pc_hold", pc, 16'h0000);
    step();
    chk("t1_pc", pc, 16'h0040);
    chk("t1_taken", 16'(taken), 16'h1);
    chk("t1_flush_c1", 16'(flush), 16'h1);
    chk("t1_ready_c2", 16'(br_ready), 16'h0);
    chk("t1_pc_valid", 16'(pc_valid), 16'h0);
    chk("t1_count", 16'(taken_count), 16'h2);
    stall = 1'b1; // ignored in FLUSH
    step();
    chk("t1_taken_pulse", 16'(taken), 16'h0);
    chk("t1_flush_c2", 16'(flush), 16'h1);
    chk("t1_ready_c3", 16'(br_ready), 16'h0);
    stall = 1'b0;
    step();
    chk("t1_flush_done", 16'(flush), 16'h0);
    chk("t1_ready_back", 16'(br_ready), 16'h1);
    chk("t1_pc_after", pc, 16'h0040);

    // Move to 0x0010, then not-taken branch racing en
    accept(16'h0010, 1'b1, 16'hFFFF);
    step(); step(); step();
    chk("t2_pc", pc, 16'h0010);
    en = 1'b1;
    accept(16'h0999, 1'b0, 16'h0000);
    chk("nt_no_inc", pc, 16'h0010);
    gt_flag = 1'b1; gt_mask = 16'hFFFF; // late operand change ignored
    step();
    en = 1'b0;
    chk("nt_pc", pc, 16'h0011);
    chk("nt_taken", 16'(taken), 16'h0);
    chk("nt_flag_err", 16'(flag_err), 16'h0);
    chk("nt_ready", 16'(br_ready), 16'h1);

    // Flag/mask mismatch
    accept(16'h0500, 1'b1, 16'h00FF);
    step();
    chk("mm_pc", pc, 16'h0012);
    chk("mm_flag_err", 16'(flag_err), 16'h1);
    chk("mm_taken", 16'(taken), 16'h0);
    chk("mm_pc_valid", 16'(pc_valid), 16'h1);
    accept(16'h0600, 1'b0, 16'h0000);
    step();
    chk("mm2_pc", pc, 16'h0013);
    chk("mm2_sticky", 16'(flag_err), 16'h1);
    chk("mm_count", 16'(taken_count), 16'h3);

    // Asynchronous reset mid-FLUSH
    accept(16'h0100, 1'b1, 16'hFFFF);
    step();
    chk("ar_in_flush", 16'(flush), 16'h1);
    rst_n = 1'b0;
    #1;
    chk("ar_pc", pc, 16'h0000);
    chk("ar_flush", 16'(flush), 16'h0);
    chk("ar_pc_valid", 16'(pc_valid), 16'h1);
    chk("ar_taken", 16'(taken), 16'h0);
    chk("ar_flag_err", 16'(flag_err), 16'h0);
    chk("ar_count", 16'(taken_count), 16'h0);
    #2;
    rst_n = 1'b1;
    step();

    // 256 taken branches saturate the counter
    for (int i = 0; i < 256; i++) begin
      accept(16'(i), 1'b1, 16'hFFFF);
      step(); step(); step();
      if (i == 254) chk("sat_254", 16'(taken_count), 16'd255);
    end
    chk("sat_255", 16'(taken_count), 16'd255);
    chk("sat_pc", pc, 16'h00FF);

    // Stall in RUN freezes pc and blocks branches
    stall = 1'b1; en = 1'b1; br_valid = 1'b1;
    br_target = 16'hABCD; gt_flag = 1'b1; gt_mask = 16'hFFFF;
    #1;
    chk("st_ready", 16'(br_ready), 16'h0);
    step(); step(); step();
    chk("st_pc", pc, 16'h00FF);
    chk("st_pc_valid", 16'(pc_valid), 16'h1);
    chk("st_taken", 16'(taken), 16'h0);
    br_valid = 1'b0; stall = 1'b0;
    step();
    chk("st_release_inc", pc, 16'h0100);
    en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
